// File: rtl/regfile_pkg.sv
// Shared constants and dump-state encoding for the register-file access controller.
package regfile_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRd,
      StOut,
      StDone
   } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Register-dump sequencer: walks every register through the rs read port and
// streams the values out over a valid/ready handshake while the pipeline is halted.
module regfile_dump_fsm
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_halted_i,
   input  logic              dump_start_i,
   input  logic              dump_ready_i,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic [ADDR_W-1:0] rd_ptr_o,
   output logic              rd_sel_o,
   output logic              dump_busy_o,
   output logic              dump_valid_o,
   output logic [DATA_W-1:0] dump_data_o,
   output logic [ADDR_W-1:0] dump_addr_o,
   output logic              dump_last_o,
   output logic              dump_done_o
);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         data_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      addr_d  = addr_q;
      case (state_q)
         StIdle: begin
            if (dump_start_i && pipe_halted_i) begin
               ptr_d   = '0;
               state_d = StRd;
            end
         end
         StRd: begin
            if (!pipe_halted_i) begin
               state_d = StDone;
            end else begin
               data_d  = rd_data_i;
               addr_d  = ptr_q;
               state_d = StOut;
            end
         end
         StOut: begin
            // Losing the halt aborts even if the consumer is accepting this cycle.
            if (!pipe_halted_i) begin
               state_d = StDone;
            end else if (dump_ready_i) begin
               if (ptr_q == LAST_IDX) begin
                  state_d = StDone;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = StRd;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign rd_ptr_o     = ptr_q;
   assign rd_sel_o     = (state_q == StRd);
   assign dump_busy_o  = (state_q == StRd) || (state_q == StOut);
   assign dump_valid_o = (state_q == StOut);
   assign dump_data_o  = data_q;
   assign dump_addr_o  = addr_q;
   assign dump_last_o  = (state_q == StOut) && (addr_q == LAST_IDX);
   assign dump_done_o  = (state_q == StDone);

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates the REGMEM write port between writeback and debug, and shares the
// rs read port between the ID stage and the register-dump sequencer.
module regfile_access_ctrl
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_halted,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic              dbg_wr_valid,
   input  logic [ADDR_W-1:0] dbg_wr_addr,
   input  logic [DATA_W-1:0] dbg_wr_data,
   output logic              dbg_wr_ready,
   input  logic              dump_start,
   output logic              dump_busy,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [ADDR_W-1:0] dump_addr,
   output logic              dump_last,
   output logic              dump_done,
   output logic [ADDR_W-1:0] rf_rs,
   input  logic [DATA_W-1:0] rf_data_1,
   output logic [ADDR_W-1:0] rf_reg_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_write_enable
);

   logic [ADDR_W-1:0] dump_ptr;
   logic              dump_rd_sel;
   logic              dbg_grant;

   regfile_dump_fsm u_dump_fsm (
      .clk           (clk),
      .reset         (reset),
      .pipe_halted_i (pipe_halted),
      .dump_start_i  (dump_start),
      .dump_ready_i  (dump_ready),
      .rd_data_i     (rf_data_1),
      .rd_ptr_o      (dump_ptr),
      .rd_sel_o      (dump_rd_sel),
      .dump_busy_o   (dump_busy),
      .dump_valid_o  (dump_valid),
      .dump_data_o   (dump_data),
      .dump_addr_o   (dump_addr),
      .dump_last_o   (dump_last),
      .dump_done_o   (dump_done)
   );

   assign rf_rs = dump_rd_sel ? dump_ptr : id_rs;

   assign dbg_wr_ready = pipe_halted & ~wb_we & ~dump_busy;
   assign dbg_grant    = dbg_wr_valid & dbg_wr_ready;

   // Enable is gated on a non-zero address so $zero can never be written.
   always_comb begin
      rf_reg_addr     = '0;
      rf_write_data   = '0;
      rf_write_enable = 1'b0;
      if (wb_we) begin
         rf_reg_addr     = wb_addr;
         rf_write_data   = wb_data;
         rf_write_enable = |wb_addr;
      end else if (dbg_grant) begin
         rf_reg_addr     = dbg_wr_addr;
         rf_write_data   = dbg_wr_data;
         rf_write_enable = |dbg_wr_addr;
      end
   end

endmodule
